// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared encodings, pipeline limits and sideband type for mult_mac_pipe
package mult_pkg;

   localparam logic MODE_MULT = 1'b0;
   localparam logic MODE_MAC  = 1'b1;

   localparam int PIPE_MIN = 3;
   localparam int PIPE_MAX = 6;

   typedef struct packed {
      logic sgn;
      logic mode;
      logic clr;
      logic zero;
   } sb_t;

endpackage

// File: rtl/mult_core.sv
// rtl/mult_core.sv - stage-2 signed/unsigned extend-and-multiply register with enable
module mult_core #(
   parameter int A_W = 15,
   parameter int B_W = 15
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic                 i_sgn,
   input  logic [A_W-1:0]       i_a,
   input  logic [B_W-1:0]       i_b,
   output logic [A_W+B_W-1:0]   o_prod
);

   localparam int P_W = A_W + B_W;

   logic [P_W-1:0] w_a_ext;
   logic [P_W-1:0] w_b_ext;
   logic [P_W-1:0] r_prod;

   // Low P_W bits of the product of the extended operands are exact for both signednesses.
   assign w_a_ext = {{B_W{i_a[A_W-1] & i_sgn}}, i_a};
   assign w_b_ext = {{A_W{i_b[B_W-1] & i_sgn}}, i_b};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prod <= '0;
      end else if (i_en) begin
         r_prod <= w_a_ext * w_b_ext;
      end
   end

   assign o_prod = r_prod;

endmodule

// File: rtl/mult_mac_pipe.sv
// rtl/mult_mac_pipe.sv - pipelined A*B multiplier with valid gating and MAC; MULT_ZERO_SKIP_EN holds datapath on zero operands
module mult_mac_pipe
   import mult_pkg::*;
#(
   parameter int A_W   = 15,
   parameter int B_W   = 15,
   parameter int PIPE  = 3,
   parameter int ACC_W = 48
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 IN_VALID,
   input  logic [A_W-1:0]       A_IN,
   input  logic [B_W-1:0]       B_IN,
   input  logic                 SIGNED_IN,
   input  logic                 MODE,
   input  logic                 ACC_CLR,
   output logic                 OUT_VALID,
   output logic [A_W+B_W-1:0]   PROD_OUT,
   output logic [ACC_W-1:0]     ACC_OUT
);

   localparam int P_W  = A_W + B_W;
   localparam int N_ST = PIPE - 2;

   if (PIPE < PIPE_MIN || PIPE > PIPE_MAX || ACC_W < P_W) begin : g_bad_params
      $error("mult_mac_pipe: illegal parameter combination");
   end

`ifdef MULT_ZERO_SKIP_EN
   localparam logic ZSKIP = 1'b1;
   logic w_zero;
   assign w_zero = (A_IN == '0) || (B_IN == '0);
`else
   localparam logic ZSKIP = 1'b0;
   logic w_zero;
   assign w_zero = 1'b0;
`endif

   logic           r_v1;
   logic [A_W-1:0] r_a;
   logic [B_W-1:0] r_b;
   sb_t            r_sb1;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_v1  <= 1'b0;
         r_a   <= '0;
         r_b   <= '0;
         r_sb1 <= '0;
      end else begin
         r_v1 <= IN_VALID;
         if (IN_VALID) begin
            r_a   <= A_IN;
            r_b   <= B_IN;
            r_sb1 <= '{sgn: SIGNED_IN, mode: MODE, clr: ACC_CLR, zero: w_zero};
         end
      end
   end

   // Index 0 is the product stage; higher indices are the delay stages.
   logic           r_v  [N_ST];
   sb_t            r_sb [N_ST];
   logic [P_W-1:0] w_p  [N_ST];
   logic           w_core_en;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < N_ST; k++) begin
            r_v[k]  <= 1'b0;
            r_sb[k] <= '0;
         end
      end else begin
         r_v[0] <= r_v1;
         if (r_v1) r_sb[0] <= r_sb1;
         for (int k = 1; k < N_ST; k++) begin
            r_v[k] <= r_v[k-1];
            if (r_v[k-1]) r_sb[k] <= r_sb[k-1];
         end
      end
   end

   assign w_core_en = r_v1 & ~(ZSKIP & r_sb1.zero);

   mult_core #(.A_W(A_W), .B_W(B_W)) u_core (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_en    (w_core_en),
      .i_sgn   (r_sb1.sgn),
      .i_a     (r_a),
      .i_b     (r_b),
      .o_prod  (w_p[0])
   );

   for (genvar k = 1; k < N_ST; k++) begin : g_dly
      logic [P_W-1:0] r_pd;
      always_ff @(posedge CLK or negedge RST) begin
         if (!RST) begin
            r_pd <= '0;
         end else if (r_v[k-1] & ~(ZSKIP & r_sb[k-1].zero)) begin
            r_pd <= w_p[k-1];
         end
      end
      assign w_p[k] = r_pd;
   end

   sb_t              w_last_sb;
   logic             w_last_v;
   logic [P_W-1:0]   w_fin_p;
   logic [ACC_W-1:0] w_ext;
   logic             r_out_v;
   logic [P_W-1:0]   r_prod_out;
   logic [ACC_W-1:0] r_acc;

   assign w_last_sb = r_sb[N_ST-1];
   assign w_last_v  = r_v[N_ST-1];
   // A skipped sample carries a stale product down the pipe; force it to zero here.
   assign w_fin_p   = w_last_sb.zero ? '0 : w_p[N_ST-1];
   assign w_ext     = w_last_sb.sgn ? ACC_W'($signed(w_fin_p)) : ACC_W'(w_fin_p);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_out_v    <= 1'b0;
         r_prod_out <= '0;
         r_acc      <= '0;
      end else begin
         r_out_v <= w_last_v;
         if (w_last_v) begin
            r_prod_out <= w_fin_p;
            if (w_last_sb.mode == MODE_MAC) begin
               r_acc <= w_last_sb.clr ? w_ext : r_acc + w_ext;
            end
         end
      end
   end

   assign OUT_VALID = r_out_v;
   assign PROD_OUT  = r_prod_out;
   assign ACC_OUT   = r_acc;

endmodule

// File: tb/tb_mult_mac_pipe.sv
// tb/tb_mult_mac_pipe.sv - directed and randomized self-checking bench for mult_mac_pipe
module tb_mult_mac_pipe;

   localparam int LAT = 3;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        IN_VALID = 1'b0;
   logic [14:0] A_IN = '0;
   logic [14:0] B_IN = '0;
   logic        SIGNED_IN = 1'b0;
   logic        MODE = 1'b0;
   logic        ACC_CLR = 1'b0;
   logic        OUT_VALID;
   logic [29:0] PROD_OUT;
   logic [47:0] ACC_OUT;

   mult_mac_pipe #(.A_W(15), .B_W(15), .PIPE(LAT), .ACC_W(48)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .A_IN      (A_IN),
      .B_IN      (B_IN),
      .SIGNED_IN (SIGNED_IN),
      .MODE      (MODE),
      .ACC_CLR   (ACC_CLR),
      .OUT_VALID (OUT_VALID),
      .PROD_OUT  (PROD_OUT),
      .ACC_OUT   (ACC_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        v;
      logic [14:0] a;
      logic [14:0] b;
      logic        s;
      logic        m;
      logic        c;
   } smp_t;

   smp_t        hist [0:2047];
   int          t = 0;
   int          checks = 0;
   int          failures = 0;
   logic        exp_v = 1'b0;
   logic [29:0] exp_prod = '0;
   logic [47:0] exp_acc = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: integer product, then take the low bits for PROD and ACC.
   function automatic void model_emit(input smp_t s);
      longint x, y, p;
      x = longint'(s.a);
      y = longint'(s.b);
      if (s.s) begin
         if (x >= 16384) x -= 32768;
         if (y >= 16384) y -= 32768;
      end
      p = x * y;
      exp_prod = p[29:0];
      if (s.m) exp_acc = s.c ? p[47:0] : exp_acc + p[47:0];
   endfunction

   task automatic check_outputs();
      chk("out_valid", 64'(OUT_VALID), 64'(exp_v));
      chk("prod_out", 64'(PROD_OUT), 64'(exp_prod));
      chk("acc_out", 64'(ACC_OUT), 64'(exp_acc));
   endtask

   task automatic step(input logic v, input logic [14:0] a, input logic [14:0] b,
                       input logic s, input logic m, input logic c);
      smp_t cur;
      int   idx;
      IN_VALID = v; A_IN = a; B_IN = b; SIGNED_IN = s; MODE = m; ACC_CLR = c;
      @(posedge CLK);
      #1;
      t++;
      cur.v = v; cur.a = a; cur.b = b; cur.s = s; cur.m = m; cur.c = c;
      hist[t] = cur;
      idx = t - (LAT - 1);
      exp_v = 1'b0;
      if (idx >= 0 && hist[idx].v) begin
         exp_v = 1'b1;
         model_emit(hist[idx]);
      end
      check_outputs();
   endtask

   task automatic idle();
      step(1'b0, 15'($urandom), 15'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic pulse_reset();
      #1;
      RST = 1'b0;
      #1;
      exp_v = 1'b0; exp_prod = '0; exp_acc = '0;
      check_outputs();
      IN_VALID = 1'b1; A_IN = 15'($urandom); B_IN = 15'($urandom);
      @(posedge CLK);
      #1;
      t++;
      for (int i = 0; i <= t; i++) hist[i] = '0;
      check_outputs();
      RST = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) hist[i] = '0;
      repeat (2) @(posedge CLK);
      #1;
      check_outputs();
      RST = 1'b1;

      step(1'b1, 15'd11950, 15'd11950, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      chk("plan_unsigned_prod", 64'(PROD_OUT), 64'h0882FE44);
      chk("plan_unsigned_valid", 64'(OUT_VALID), 64'd1);
      chk("plan_unsigned_acc", 64'(ACC_OUT), 64'd0);
      idle();

      step(1'b1, 15'h7FFF, 15'h7FFF, 1'b1, 1'b0, 1'b0);
      step(1'b1, 15'h7FFF, 15'h7FFF, 1'b0, 1'b0, 1'b0);
      idle();
      chk("plan_signed_prod", 64'(PROD_OUT), 64'h1);
      idle();
      chk("plan_unsigned_max_prod", 64'(PROD_OUT), 64'h3FFF0001);
      chk("plan_backtoback_valid", 64'(OUT_VALID), 64'd1);

      step(1'b1, 15'd2020, 15'd2020, 1'b0, 1'b1, 1'b1);
      step(1'b1, 15'd2020, 15'd2020, 1'b0, 1'b1, 1'b0);
      step(1'b1, 15'd2020, 15'd2020, 1'b0, 1'b1, 1'b0);
      chk("plan_mac_1", 64'(ACC_OUT), 64'd4080400);
      step(1'b1, 15'd2020, 15'd2020, 1'b0, 1'b1, 1'b0);
      chk("plan_mac_2", 64'(ACC_OUT), 64'd8160800);
      idle();
      chk("plan_mac_3", 64'(ACC_OUT), 64'd12241200);
      idle();
      chk("plan_mac_4", 64'(ACC_OUT), 64'd16321600);

      step(1'b1, 15'd123, 15'd456, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      step(1'b1, 15'd789, 15'd1011, 1'b1, 1'b0, 1'b0);
      idle();
      chk("plan_bubble_hold", 64'(PROD_OUT), 64'd56088);
      idle();
      idle();

      step(1'b1, 15'd300, 15'd300, 1'b0, 1'b1, 1'b1);
      step(1'b1, 15'd301, 15'd301, 1'b0, 1'b1, 1'b0);
      step(1'b1, 15'd302, 15'd302, 1'b0, 1'b1, 1'b0);
      pulse_reset();
      step(1'b1, 15'd100, 15'd200, 1'b0, 1'b0, 1'b0);
      idle();
      chk("plan_reset_no_valid", 64'(OUT_VALID), 64'd0);
      idle();
      chk("plan_reset_next_prod", 64'(PROD_OUT), 64'd20000);
      chk("plan_reset_next_valid", 64'(OUT_VALID), 64'd1);

      step(1'b1, 15'd1115, 15'd1115, 1'b0, 1'b1, 1'b1);
      step(1'b1, 15'd0, 15'd12157, 1'b0, 1'b1, 1'b0);
      idle();
      chk("plan_zero_acc_pre", 64'(ACC_OUT), 64'd1243225);
      idle();
      chk("plan_zero_prod", 64'(PROD_OUT), 64'd0);
      chk("plan_zero_acc", 64'(ACC_OUT), 64'd1243225);
      chk("plan_zero_valid", 64'(OUT_VALID), 64'd1);

      for (int n = 0; n < 400; n++) begin
         logic [14:0] ra, rb;
         ra = 15'($urandom);
         rb = 15'($urandom);
         if ($urandom_range(0, 9) == 0) ra = '0;
         if ($urandom_range(0, 9) == 0) rb = '0;
         if (n == 200) pulse_reset();
         step(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 7) == 0));
      end
      repeat (LAT) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_mac_pipe.md
Name: mult_mac_pipe

Overview:
- Parametrised successor to the fixed 15x15 low-power multiplier in the dsp48e_application block set.
- Pipelined A×B multiplier with valid qualification, run-time signed/unsigned selection and an optional multiply-accumulate mode.
- Operand registers load only on valid data, so idle cycles do not toggle the datapath.
- Sits between sample sources (filters, mixers) and downstream DSP48E-style accumulation/scaling logic.

Parameters:
A_W, 15, operand A width (2..25)
B_W, 15, operand B width (2..18)
PIPE, 3, total latency in cycles from IN_VALID to OUT_VALID (3..6)
ACC_W, 48, accumulator width (must be ≥ A_W+B_W)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-low reset; asserted (0) clears all state immediately
IN_VALID  in  1  A_IN/B_IN/MODE/SIGNED_IN/ACC_CLR valid this cycle
A_IN  in  A_W  operand A
B_IN  in  B_W  operand B
SIGNED_IN  in  1  1 = two's-complement operands, 0 = unsigned
MODE  in  1  0 = multiply only, 1 = multiply-accumulate
ACC_CLR  in  1  with MODE=1: this sample restarts the accumulator (acc = product)
OUT_VALID  out  1  PROD_OUT/ACC_OUT updated this cycle
PROD_OUT  out  A_W+B_W  product, signed or unsigned per the sample's SIGNED_IN
ACC_OUT  out  ACC_W  accumulator value

Behaviour:
- Reset (RST=0, async): OUT_VALID=0, PROD_OUT=0, ACC_OUT=0; all pipeline data and valid bits 0. Release is synchronous to the next CLK edge in the bench; the first valid input is accepted on the first edge with RST=1.
- Stage 1: input registers capture A_IN, B_IN and control bits only when IN_VALID=1, otherwise hold (low-power gating). A valid bit is always shifted.
- Stage 2: full-width product of the stage-1 operands. Operands are sign-extended when SIGNED_IN=1 and zero-extended otherwise. The product register loads only when its stage valid=1.
- Stages 3..PIPE-1: delay registers, each enabled by its own valid bit.
- Final stage: PROD_OUT loads the product. OUT_VALID = valid bit of the final stage.
- Latency: exactly PIPE edges from the IN_VALID edge to OUT_VALID=1. Throughput is one sample per cycle. Bubbles propagate unchanged, with no reordering.
- Accumulator, updated only on a final-stage valid with MODE=1:
  - ACC_CLR=1: acc ← ext(product).
  - ACC_CLR=0: acc ← acc + ext(product).
  - ext() is sign- or zero-extension to ACC_W per SIGNED_IN.
  - Wrap-around modulo 2^ACC_W; no saturation.
- With MODE=0 the accumulator holds and ACC_OUT is unchanged.
- When OUT_VALID=0, PROD_OUT and ACC_OUT hold their last values.
- MODE, SIGNED_IN and ACC_CLR travel with their sample; changing them mid-stream affects only the samples they accompany.
- RST asserted mid-stream: all in-flight samples are discarded and no OUT_VALID pulse is produced for them.
- IN_VALID=1 on the edge RST deasserts is accepted normally.

Optional Feature:
- Macro MULT_ZERO_SKIP_EN.
- Defined: stage 1 detects A_IN==0 or B_IN==0 and sets a zero flag. Stage 2 and the delay registers do not load operand/product data for that sample (they hold); the final stage forces PROD_OUT=0 and adds 0 to the accumulator. Valid timing and latency are unchanged.
- Not defined: zero operands are multiplied normally. Results are identical; only datapath toggling differs.

Decomposition:
- Shared package mult_pkg: mode encodings (MODE_MULT=0, MODE_MAC=1), the PIPE legal-range constants, and a packed sideband struct {signed, mode, clr, zero} carried down the pipeline.
- One natural sub-module: mult_core, the stage-2 signed/unsigned extend-and-multiply register with enable.
- Top-level mult_mac_pipe owns the valid pipeline, delay stages and accumulator.

Test Plan:
- Unsigned, PIPE=3: A=B=11950, IN_VALID one cycle → after 3 edges OUT_VALID=1 for one cycle, PROD_OUT=30'h0882FE44; ACC_OUT stays 0 (MODE=0).
- Signedness: A=B=15'h7FFF with SIGNED_IN=1 → PROD_OUT=30'h0000_0001. Same operands with SIGNED_IN=0 → 30'h3FFF0001. Sent back-to-back, the outputs appear on consecutive cycles.
- MAC: four consecutive samples A=B=2020, MODE=1, ACC_CLR=1 on the first only → ACC_OUT successively 4080400, 8160800, 12241200, 16321600.
- Bubbles and hold: valid, idle, idle, valid samples → OUT_VALID pattern 1,0,0,1 after latency; PROD_OUT holds during the gap; input registers do not change while IN_VALID=0.
- Reset mid-stream: 3 samples in flight, RST=0 for one cycle → outputs 0 immediately, no OUT_VALID for the discarded samples; the next sample after release emerges with normal latency.
- MULT_ZERO_SKIP_EN build: A=0, B=12157, MODE=1 following acc=1115*1115=1243225 → PROD_OUT=0, ACC_OUT=1243225, latency unchanged. Without the macro the results are identical.
